// File: rtl/stack_resolver_pkg.sv
// Purpose: shared game constants, direction encodings and FSM state encoding for the stacker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_resolver_pkg;

   localparam int DEF_X_MAX      = 144;
   localparam int DEF_INIT_WIDTH = 16;
   localparam int DEF_BASE_X     = 72;
   localparam int DEF_MAX_LEVEL  = 20;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPAWN,
      ST_MOVING,
      ST_CAPTURE,
      ST_COMPUTE,
      ST_COMMIT,
      ST_LOSE,
      ST_WIN
   } state_t;

endpackage

// File: rtl/stack_resolver_overlap_calc.sv
// Purpose: overlap of the dropped block [c, c+w) with the landed block [p, p+w).
// Latency: purely combinational.
// Backpressure: none.
module overlap_calc (
   input  logic [7:0] c,
   input  logic [7:0] p,
   input  logic [7:0] w,
   output logic [7:0] left,
   output logic [7:0] overlap
);

   logic [8:0] c_end;
   logic [8:0] p_end;
   logic [8:0] right;
   logic [8:0] diff;

   // Bit 8 of diff is the borrow: a positive overlap is at most w, so a clear
   // borrow means right >= left and the low byte is the overlap itself.
   always_comb begin
      left    = (c > p) ? c : p;
      c_end   = {1'b0, c} + {1'b0, w};
      p_end   = {1'b0, p} + {1'b0, w};
      right   = (c_end < p_end) ? c_end : p_end;
      diff    = right - {1'b0, left};
      overlap = diff[8] ? 8'd0 : diff[7:0];
   end

endmodule

// File: rtl/stack_resolver.sv
// Purpose: stacker game FSM -- spawns moving blocks, captures drops, trims and stacks them.
// Latency: drop sampled in MOVING -> done exactly 3 cycles later (CAPTURE, COMPUTE, COMMIT).
// Backpressure: none; drop outside MOVING is ignored, start always wins.
module stack_resolver
   import stack_resolver_pkg::*;
#(
   parameter int X_MAX      = DEF_X_MAX,
   parameter int INIT_WIDTH = DEF_INIT_WIDTH,
   parameter int BASE_X     = DEF_BASE_X,
   parameter int MAX_LEVEL  = DEF_MAX_LEVEL
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       drop,
   input  logic [7:0] curr_x_position,
   output logic       move_en,
   output logic       load_x,
   output logic [7:0] new_x_position,
   output logic       load_direction,
   output logic       new_direction,
   output logic [7:0] block_width,
   output logic [7:0] base_x,
   output logic [4:0] level,
   output logic       done,
   output logic       perfect,
   output logic       game_over,
   output logic       win
);

   localparam logic [7:0] X_MAX_V      = 8'(X_MAX);
   localparam logic [7:0] INIT_WIDTH_V = 8'(INIT_WIDTH);
   localparam logic [7:0] BASE_X_V     = 8'(BASE_X);
   localparam logic [4:0] MAX_LEVEL_V  = 5'(MAX_LEVEL);

   state_t     state_q, state_d;
   logic [7:0] width_q, width_d;
   logic [7:0] base_q,  base_d;
   logic [4:0] level_q, level_d;
   logic [7:0] c_q,     c_d;
   logic [7:0] left_q,  left_d;
   logic [7:0] ovl_q,   ovl_d;

   logic [7:0] calc_left;
   logic [7:0] calc_ovl;

   overlap_calc u_overlap_calc (
      .c       (c_q),
      .p       (base_q),
      .w       (width_q),
      .left    (calc_left),
      .overlap (calc_ovl)
   );

   // State and game registers; reset abandons any landing in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         width_q <= INIT_WIDTH_V;
         base_q  <= BASE_X_V;
         level_q <= 5'd0;
         c_q     <= 8'd0;
         left_q  <= 8'd0;
         ovl_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         width_q <= width_d;
         base_q  <= base_d;
         level_q <= level_d;
         c_q     <= c_d;
         left_q  <= left_d;
         ovl_q   <= ovl_d;
      end
   end

   // Next-state and Moore outputs; start overrides whatever the FSM chose.
   always_comb begin
      state_d        = state_q;
      width_d        = width_q;
      base_d         = base_q;
      level_d        = level_q;
      c_d            = c_q;
      left_d         = left_q;
      ovl_d          = ovl_q;
      move_en        = 1'b0;
      load_x         = 1'b0;
      load_direction = 1'b0;
      new_x_position = 8'd0;
      new_direction  = DIR_RIGHT;
      done           = 1'b0;
      perfect        = 1'b0;
      game_over      = 1'b0;
      win            = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_SPAWN: begin
            // Blocks alternate sides: even levels enter from the left edge.
            load_x         = 1'b1;
            load_direction = 1'b1;
            new_x_position = level_q[0] ? X_MAX_V : 8'd0;
            new_direction  = level_q[0] ? DIR_LEFT : DIR_RIGHT;
            state_d        = ST_MOVING;
         end
         ST_MOVING: begin
            move_en = 1'b1;
            if (drop) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            c_d     = curr_x_position;
            state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            left_d  = calc_left;
            ovl_d   = calc_ovl;
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            done = 1'b1;
            if (ovl_q == 8'd0) begin
               state_d = ST_LOSE;
            end else begin
               perfect = (c_q == base_q);
               base_d  = left_q;
               width_d = ovl_q;
               level_d = (level_q == MAX_LEVEL_V) ? level_q : level_q + 5'd1;
               state_d = (level_d == MAX_LEVEL_V) ? ST_WIN : ST_SPAWN;
            end
         end
         ST_LOSE: begin
            game_over = 1'b1;
         end
         ST_WIN: begin
            win = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start) begin
         state_d = ST_SPAWN;
         width_d = INIT_WIDTH_V;
         base_d  = BASE_X_V;
         level_d = 5'd0;
      end
   end

   assign block_width = width_q;
   assign base_x      = base_q;
   assign level       = level_q;

endmodule

// File: tb/tb_stack_resolver.sv
// Purpose: scoreboard bench for stack_resolver -- expected landings queued at drop, checked at done.
// Latency: checks done exactly 3 cycles after the drop is sampled.
// Backpressure: n/a.
module tb_stack_resolver;

   localparam int MAXL = 20;

   logic       clk;
   logic       resetn;
   logic       start;
   logic       drop;
   logic [7:0] curr_x_position;
   logic       move_en;
   logic       load_x;
   logic [7:0] new_x_position;
   logic       load_direction;
   logic       new_direction;
   logic [7:0] block_width;
   logic [7:0] base_x;
   logic [4:0] level;
   logic       done;
   logic       perfect;
   logic       game_over;
   logic       win;

   stack_resolver dut (
      .clk             (clk),
      .resetn          (resetn),
      .start           (start),
      .drop            (drop),
      .curr_x_position (curr_x_position),
      .move_en         (move_en),
      .load_x          (load_x),
      .new_x_position  (new_x_position),
      .load_direction  (load_direction),
      .new_direction   (new_direction),
      .block_width     (block_width),
      .base_x          (base_x),
      .level           (level),
      .done            (done),
      .perfect         (perfect),
      .game_over       (game_over),
      .win             (win)
   );

   typedef struct {
      int   cyc;
      logic perf;
      int   w;
      int   b;
      int   lvl;
      logic go;
      logic wn;
   } exp_t;

   exp_t sb[$];
   exp_t post;
   bit   post_pend = 0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   // bench-side game model
   int mw, mb, ml;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   // Monitor: pop at done, then check the committed state one cycle later.
   always @(negedge clk) begin
      if (post_pend) begin
         chk("post_width", block_width, post.w);
         chk("post_base", base_x, post.b);
         chk("post_level", level, post.lvl);
         chk("post_game_over", game_over, post.go);
         chk("post_win", win, post.wn);
         chk("post_move_en", move_en, 0);
         post_pend = 0;
      end
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            post = sb.pop_front();
            chk("done_latency", cyc, post.cyc);
            chk("perfect", perfect, post.perf);
            post_pend = 1;
         end
      end else if (perfect) begin
         chk("perfect_without_done", 1, 0);
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mw = 16; mb = 72; ml = 0;
      chk("spawn_load_x", load_x, 1);
      chk("spawn_load_dir", load_direction, 1);
      chk("spawn_new_x", new_x_position, 0);
      chk("spawn_new_dir", new_direction, 1);
      chk("start_level", level, 0);
      chk("start_width", block_width, 16);
      chk("start_base", base_x, 72);
   endtask

   task automatic do_drop(input int x);
      exp_t e;
      int   lft, rgt, ovl;
      bit   ok;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (move_en) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("move_en_wait", 0, 1);
         return;
      end
      lft = (x > mb) ? x : mb;
      rgt = ((x + mw) < (mb + mw)) ? (x + mw) : (mb + mw);
      ovl = (rgt > lft) ? (rgt - lft) : 0;
      e.cyc  = cyc + 3;
      e.perf = (ovl > 0) && (x == mb);
      e.go   = (ovl == 0);
      if (ovl > 0) begin
         mb = lft;
         mw = ovl;
         if (ml < MAXL) ml++;
      end
      e.w   = mw;
      e.b   = mb;
      e.lvl = ml;
      e.wn  = (ovl > 0) && (ml == MAXL);
      sb.push_back(e);
      drop = 1'b1;
      curr_x_position = 8'(x);
      @(negedge clk);
      drop = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !post_pend) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("landing_timeout", 0, 1);
         sb.delete();
         return;
      end
      if (!e.go && !e.wn) begin
         chk("respawn_load_x", load_x, 1);
         chk("respawn_new_x", new_x_position, (ml % 2) ? 144 : 0);
         chk("respawn_new_dir", new_direction, (ml % 2) ? 0 : 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      start = 1'b0;
      drop = 1'b0;
      curr_x_position = 8'd0;
      #12;
      chk("rst_level", level, 0);
      chk("rst_width", block_width, 16);
      chk("rst_base", base_x, 72);
      chk("rst_move_en", move_en, 0);
      chk("rst_load_x", load_x, 0);
      chk("rst_done", done, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_win", win, 0);
      @(negedge clk);
      resetn = 1'b1;

      // drop in IDLE is ignored
      drop = 1'b1;
      @(negedge clk);
      drop = 1'b0;
      @(negedge clk);
      chk("idle_drop_move_en", move_en, 0);
      chk("idle_drop_load_x", load_x, 0);

      // perfect landing, then a second level that must spawn from the right
      do_start();
      do_drop(72);
      chk("perfect_level", level, 1);

      // partial right, then a further trim on level 1
      do_start();
      do_drop(80);
      do_drop(76);

      // partial left
      do_start();
      do_drop(60);

      // miss: lose, and drops are ignored afterwards
      do_start();
      do_drop(100);
      drop = 1'b1;
      repeat (2) @(negedge clk);
      drop = 1'b0;
      repeat (4) @(negedge clk);
      chk("lose_game_over_hold", game_over, 1);
      chk("lose_move_en", move_en, 0);
      chk("lose_load_x", load_x, 0);
      chk("lose_level", level, 0);

      // win after MAX_LEVEL perfect drops, then restart
      do_start();
      for (int i = 0; i < MAXL; i++) do_drop(72);
      repeat (3) @(negedge clk);
      chk("win_hold", win, 1);
      chk("win_level", level, MAXL);
      chk("win_move_en", move_en, 0);
      chk("win_load_x", load_x, 0);
      do_start();
      chk("restart_win", win, 0);

      // async reset during COMPUTE abandons the landing
      do_drop(80);
      for (int i = 0; i < 50 && !move_en; i++) @(negedge clk);
      drop = 1'b1;
      curr_x_position = 8'd72;
      @(posedge clk);
      #1 drop = 1'b0;
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_level", level, 0);
      chk("arst_width", block_width, 16);
      chk("arst_base", base_x, 72);
      chk("arst_done", done, 0);
      chk("arst_move_en", move_en, 0);
      chk("arst_game_over", game_over, 0);
      chk("arst_win", win, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      chk("arst_idle_move_en", move_en, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
